// File: rtl/render_scheduler_if.sv
// Render scheduler bus bundle: three drawing clients (map, sprite, HUD)
// sharing one ROM address port and one VGA adapter write bus. The master
// modport is the scheduler side, the slave modport is the client/adapter side.
interface render_scheduler_if;
    // Scheduling control
    logic        hud_en;
    logic        map_start;
    logic        spr_start;
    logic        hud_start;
    logic        map_done;
    logic        spr_done;
    logic        hud_done;

    // Client ROM requests
    logic [15:0] map_rom_addr;
    logic [15:0] spr_rom_addr;
    logic [15:0] hud_rom_addr;

    // Client pixel writes
    logic        map_plot;
    logic        spr_plot;
    logic        hud_plot;
    logic [7:0]  map_x;
    logic [7:0]  spr_x;
    logic [7:0]  hud_x;
    logic [6:0]  map_y;
    logic [6:0]  spr_y;
    logic [6:0]  hud_y;
    logic [23:0] map_colour;
    logic [23:0] spr_colour;
    logic [23:0] hud_colour;

    // Shared resources and status
    logic [15:0] rom_address;
    logic        vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [23:0] vga_colour;
    logic [2:0]  grant;
    logic        frame_done;
    logic [2:0]  timeout_flags;

    modport master (
        input  hud_en,
        input  map_done, spr_done, hud_done,
        input  map_rom_addr, spr_rom_addr, hud_rom_addr,
        input  map_plot, spr_plot, hud_plot,
        input  map_x, spr_x, hud_x,
        input  map_y, spr_y, hud_y,
        input  map_colour, spr_colour, hud_colour,
        output map_start, spr_start, hud_start,
        output rom_address,
        output vga_plot, vga_x, vga_y, vga_colour,
        output grant, frame_done, timeout_flags
    );

    modport slave (
        output hud_en,
        output map_done, spr_done, hud_done,
        output map_rom_addr, spr_rom_addr, hud_rom_addr,
        output map_plot, spr_plot, hud_plot,
        output map_x, spr_x, hud_x,
        output map_y, spr_y, hud_y,
        output map_colour, spr_colour, hud_colour,
        input  map_start, spr_start, hud_start,
        input  rom_address,
        input  vga_plot, vga_x, vga_y, vga_colour,
        input  grant, frame_done, timeout_flags
    );
endinterface

// File: rtl/render_scheduler.sv
// Per-frame render scheduler: runs the map drawer, then the sprite drawer,
// then (optionally) the HUD drawer, handing each one exclusive use of the
// ROM port and the VGA bus. A watchdog forces release of a stuck client and
// records the expiry in a sticky flag. frame_reset restarts the schedule.
module render_scheduler #(
    parameter logic [19:0] WATCHDOG = 20'd65535
) (
    input  logic               CLOCK_50,
    input  logic               frame_reset,
    render_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        ARM     = 3'd0,
        MAP_RUN = 3'd1,
        SPR_RUN = 3'd2,
        HUD_RUN = 3'd3,
        FINISH  = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic [19:0] watchdog_reg, watchdog_next;
    logic [2:0]  grant_reg, grant_next;
    logic [2:0]  start_reg, start_next;
    logic        frame_done_reg, frame_done_next;
    logic [2:0]  timeout_reg, timeout_next;
    logic        vga_plot_reg, vga_plot_next;
    logic [7:0]  vga_x_reg, vga_x_next;
    logic [6:0]  vga_y_reg, vga_y_next;
    logic [23:0] vga_colour_reg, vga_colour_next;

    // Client signals packed by client index: 0 = map, 1 = sprite, 2 = HUD,
    // matching the bit order of grant.
    logic [2:0]  done_vec;
    logic [2:0]  plot_vec;
    logic [15:0] addr_arr   [3];
    logic [7:0]  x_arr      [3];
    logic [6:0]  y_arr      [3];
    logic [23:0] colour_arr [3];

    assign done_vec      = {bus.hud_done, bus.spr_done, bus.map_done};
    assign plot_vec      = {bus.hud_plot, bus.spr_plot, bus.map_plot};
    assign addr_arr[0]   = bus.map_rom_addr;
    assign addr_arr[1]   = bus.spr_rom_addr;
    assign addr_arr[2]   = bus.hud_rom_addr;
    assign x_arr[0]      = bus.map_x;
    assign x_arr[1]      = bus.spr_x;
    assign x_arr[2]      = bus.hud_x;
    assign y_arr[0]      = bus.map_y;
    assign y_arr[1]      = bus.spr_y;
    assign y_arr[2]      = bus.hud_y;
    assign colour_arr[0] = bus.map_colour;
    assign colour_arr[1] = bus.spr_colour;
    assign colour_arr[2] = bus.hud_colour;

    // One-hot AND-OR mux terms: each client contributes only while granted,
    // so a non-granted client can never leak onto the shared buses.
    logic [15:0] addr_term   [3];
    logic [7:0]  x_term      [3];
    logic [6:0]  y_term      [3];
    logic [23:0] colour_term [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_client
            assign addr_term[gi]   = grant_reg[gi] ? addr_arr[gi]   : 16'h0000;
            assign x_term[gi]      = grant_reg[gi] ? x_arr[gi]      : 8'h00;
            assign y_term[gi]      = grant_reg[gi] ? y_arr[gi]      : 7'h00;
            assign colour_term[gi] = grant_reg[gi] ? colour_arr[gi] : 24'h000000;
        end
    endgenerate

    logic [15:0] rom_mux;
    logic [7:0]  x_mux;
    logic [6:0]  y_mux;
    logic [23:0] colour_mux;

    assign rom_mux    = addr_term[0]   | addr_term[1]   | addr_term[2];
    assign x_mux      = x_term[0]      | x_term[1]      | x_term[2];
    assign y_mux      = y_term[0]      | y_term[1]      | y_term[2];
    assign colour_mux = colour_term[0] | colour_term[1] | colour_term[2];

    // Run-state qualifiers shared by the next-state and output logic.
    logic in_run;
    logic granted_done;
    logic wd_expired;
    logic run_exit;

    assign in_run       = (state_reg == MAP_RUN) || (state_reg == SPR_RUN) ||
                          (state_reg == HUD_RUN);
    assign granted_done = |(done_vec & grant_reg);
    assign wd_expired   = (watchdog_reg == (WATCHDOG - 20'd1));
    assign run_exit     = in_run && (granted_done || wd_expired);

    // State register; frame_reset aborts any run immediately.
    always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
        if (frame_reset) begin
            state_reg <= ARM;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: fixed map -> sprite -> (HUD) order, one frame per reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARM:     state_next = MAP_RUN;
            MAP_RUN: if (run_exit) state_next = SPR_RUN;
            SPR_RUN: if (run_exit) state_next = bus.hud_en ? HUD_RUN : FINISH;
            HUD_RUN: if (run_exit) state_next = FINISH;
            FINISH:  state_next = HOLD;
            HOLD:    state_next = HOLD;
            default: state_next = ARM;
        endcase
    end

    // Output decode from the upcoming state so grant/start/frame_done are
    // registered and change on the same edge as the state.
    always_comb begin
        case (state_next)
            MAP_RUN: grant_next = 3'b001;
            SPR_RUN: grant_next = 3'b010;
            HUD_RUN: grant_next = 3'b100;
            default: grant_next = 3'b000;
        endcase

        // A start pulse marks only the first cycle of a RUN state.
        start_next      = (state_next != state_reg) ? grant_next : 3'b000;
        frame_done_next = (state_next == FINISH);

        // Watchdog restarts from zero on every RUN entry.
        watchdog_next = 20'd0;
        if (in_run && (state_next == state_reg)) begin
            watchdog_next = watchdog_reg + 20'd1;
        end

        // A completing client wins over a simultaneous watchdog expiry.
        timeout_next = timeout_reg;
        if (in_run && wd_expired && !granted_done) begin
            timeout_next = timeout_reg | grant_reg;
        end

        vga_plot_next   = |(plot_vec & grant_reg);
        vga_x_next      = x_mux;
        vga_y_next      = y_mux;
        vga_colour_next = colour_mux;
    end

    // Output and datapath registers.
    always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
        if (frame_reset) begin
            watchdog_reg   <= 20'd0;
            grant_reg      <= 3'b000;
            start_reg      <= 3'b000;
            frame_done_reg <= 1'b0;
            timeout_reg    <= 3'b000;
            vga_plot_reg   <= 1'b0;
            vga_x_reg      <= 8'h00;
            vga_y_reg      <= 7'h00;
            vga_colour_reg <= 24'h000000;
        end else begin
            watchdog_reg   <= watchdog_next;
            grant_reg      <= grant_next;
            start_reg      <= start_next;
            frame_done_reg <= frame_done_next;
            timeout_reg    <= timeout_next;
            vga_plot_reg   <= vga_plot_next;
            vga_x_reg      <= vga_x_next;
            vga_y_reg      <= vga_y_next;
            vga_colour_reg <= vga_colour_next;
        end
    end

    // ROM address stays combinational so client ROM latency is unchanged.
    assign bus.rom_address   = rom_mux;
    assign bus.map_start     = start_reg[0];
    assign bus.spr_start     = start_reg[1];
    assign bus.hud_start     = start_reg[2];
    assign bus.grant         = grant_reg;
    assign bus.frame_done    = frame_done_reg;
    assign bus.timeout_flags = timeout_reg;
    assign bus.vga_plot      = vga_plot_reg;
    assign bus.vga_x         = vga_x_reg;
    assign bus.vga_y         = vga_y_reg;
    assign bus.vga_colour    = vga_colour_reg;

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler: a default-watchdog instance for the
// normal schedules and a WATCHDOG=16 instance for timeout and abort cases.
module tb_render_scheduler;

    logic CLOCK_50;
    logic frame_reset;

    int checks;
    int failures;

    // Per-frame record filled by run_frame
    int         map_start_cyc, spr_start_cyc, hud_start_cyc, fd_cyc;
    int         map_w, spr_w, hud_w, fd_cnt;
    logic [2:0] grant_log [0:255];

    render_scheduler_if bus();
    render_scheduler_if bus_wd();

    render_scheduler dut (
        .CLOCK_50    (CLOCK_50),
        .frame_reset (frame_reset),
        .bus         (bus)
    );

    render_scheduler #(.WATCHDOG(20'd16)) dut_wd (
        .CLOCK_50    (CLOCK_50),
        .frame_reset (frame_reset),
        .bus         (bus_wd)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic init_inputs();
        bus.hud_en = 0; bus.map_done = 0; bus.spr_done = 0; bus.hud_done = 0;
        bus.map_rom_addr = 0; bus.spr_rom_addr = 0; bus.hud_rom_addr = 0;
        bus.map_plot = 0; bus.spr_plot = 0; bus.hud_plot = 0;
        bus.map_x = 0; bus.spr_x = 0; bus.hud_x = 0;
        bus.map_y = 0; bus.spr_y = 0; bus.hud_y = 0;
        bus.map_colour = 0; bus.spr_colour = 0; bus.hud_colour = 0;
        bus_wd.hud_en = 0; bus_wd.map_done = 0; bus_wd.spr_done = 0; bus_wd.hud_done = 0;
        bus_wd.map_rom_addr = 0; bus_wd.spr_rom_addr = 0; bus_wd.hud_rom_addr = 0;
        bus_wd.map_plot = 0; bus_wd.spr_plot = 0; bus_wd.hud_plot = 0;
        bus_wd.map_x = 0; bus_wd.spr_x = 0; bus_wd.hud_x = 0;
        bus_wd.map_y = 0; bus_wd.spr_y = 0; bus_wd.hud_y = 0;
        bus_wd.map_colour = 0; bus_wd.spr_colour = 0; bus_wd.hud_colour = 0;
    endtask

    // Pulse reset over one posedge and release at a negedge; the next
    // posedge starts cycle 1 (ARM -> MAP_RUN).
    task automatic apply_reset();
        frame_reset = 1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        frame_reset = 0;
    endtask

    // Run the default instance for ncyc cycles; each client answers done
    // a fixed number of cycles after its observed start pulse.
    task automatic run_frame(input int map_dly, input int spr_dly, input int hud_dly,
                             input int ncyc);
        map_start_cyc = -1; spr_start_cyc = -1; hud_start_cyc = -1; fd_cyc = -1;
        map_w = 0; spr_w = 0; hud_w = 0; fd_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge CLOCK_50);
            grant_log[c] = bus.grant;
            if (bus.map_start) begin map_w++; if (map_start_cyc < 0) map_start_cyc = c; end
            if (bus.spr_start) begin spr_w++; if (spr_start_cyc < 0) spr_start_cyc = c; end
            if (bus.hud_start) begin hud_w++; if (hud_start_cyc < 0) hud_start_cyc = c; end
            if (bus.frame_done) begin fd_cnt++; if (fd_cyc < 0) fd_cyc = c; end
            bus.map_done = (map_start_cyc >= 0) && (c == map_start_cyc + map_dly);
            bus.spr_done = (spr_start_cyc >= 0) && (c == spr_start_cyc + spr_dly);
            bus.hud_done = (hud_start_cyc >= 0) && (c == hud_start_cyc + hud_dly);
        end
        bus.map_done = 0; bus.spr_done = 0; bus.hud_done = 0;
        $display("frame: map@%0d spr@%0d hud@%0d frame_done@%0d (x%0d)",
                 map_start_cyc, spr_start_cyc, hud_start_cyc, fd_cyc, fd_cnt);
    endtask

    task automatic test_reset();
        init_inputs();
        bus.map_plot = 1; bus.map_x = 8'h55; bus.map_colour = 24'h123456; bus.map_rom_addr = 16'hBEEF;
        bus.map_done = 1;
        frame_reset = 1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL reset_grant actual=%b required=000", bus.grant); end
        checks++; if ({bus.hud_start, bus.spr_start, bus.map_start} !== 3'b000) begin failures++; $display("FAIL reset_starts actual=%b required=000", {bus.hud_start, bus.spr_start, bus.map_start}); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done actual=%b required=0", bus.frame_done); end
        checks++; if (bus.vga_plot !== 1'b0) begin failures++; $display("FAIL reset_vga_plot actual=%b required=0", bus.vga_plot); end
        checks++; if (bus.vga_x !== 8'h00 || bus.vga_y !== 7'h00) begin failures++; $display("FAIL reset_vga_xy actual=%h,%h required=00,00", bus.vga_x, bus.vga_y); end
        checks++; if (bus.vga_colour !== 24'h000000) begin failures++; $display("FAIL reset_vga_colour actual=%h required=000000", bus.vga_colour); end
        checks++; if (bus.timeout_flags !== 3'b000) begin failures++; $display("FAIL reset_timeout actual=%b required=000", bus.timeout_flags); end
        checks++; if (bus.rom_address !== 16'h0000) begin failures++; $display("FAIL reset_rom_address actual=%h required=0000", bus.rom_address); end
        $display("test_reset: checked outputs while frame_reset held");
        init_inputs();
    endtask

    task automatic test_no_hud();
        init_inputs();
        bus.hud_en = 0;
        apply_reset();
        run_frame(100, 64, 0, 200);
        checks++; if (map_start_cyc !== 1) begin failures++; $display("FAIL nohud_map_start_cyc actual=%0d required=1", map_start_cyc); end
        checks++; if (spr_start_cyc !== 102) begin failures++; $display("FAIL nohud_spr_start_cyc actual=%0d required=102", spr_start_cyc); end
        checks++; if (hud_start_cyc !== -1) begin failures++; $display("FAIL nohud_hud_start actual=%0d required=-1", hud_start_cyc); end
        checks++; if (fd_cyc !== 167) begin failures++; $display("FAIL nohud_frame_done_cyc actual=%0d required=167", fd_cyc); end
        checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL nohud_frame_done_count actual=%0d required=1", fd_cnt); end
        checks++; if (grant_log[101] !== 3'b001) begin failures++; $display("FAIL nohud_grant_101 actual=%b required=001", grant_log[101]); end
        checks++; if (grant_log[102] !== 3'b010) begin failures++; $display("FAIL nohud_grant_102 actual=%b required=010", grant_log[102]); end
        checks++; if (grant_log[166] !== 3'b010) begin failures++; $display("FAIL nohud_grant_166 actual=%b required=010", grant_log[166]); end
        checks++; if (grant_log[167] !== 3'b000) begin failures++; $display("FAIL nohud_grant_167 actual=%b required=000", grant_log[167]); end
        checks++; if (grant_log[200] !== 3'b000) begin failures++; $display("FAIL nohud_grant_hold actual=%b required=000", grant_log[200]); end
        checks++; if (map_w !== 1 || spr_w !== 1) begin failures++; $display("FAIL nohud_start_width actual=%0d,%0d required=1,1", map_w, spr_w); end
        checks++; if (bus.timeout_flags !== 3'b000) begin failures++; $display("FAIL nohud_timeout actual=%b required=000", bus.timeout_flags); end
    endtask

    task automatic test_with_hud();
        init_inputs();
        bus.hud_en = 1;
        apply_reset();
        run_frame(3, 5, 7, 40);
        checks++; if (map_start_cyc !== 1) begin failures++; $display("FAIL hud_map_start_cyc actual=%0d required=1", map_start_cyc); end
        checks++; if (spr_start_cyc !== 5) begin failures++; $display("FAIL hud_spr_start_cyc actual=%0d required=5", spr_start_cyc); end
        checks++; if (hud_start_cyc !== 11) begin failures++; $display("FAIL hud_hud_start_cyc actual=%0d required=11", hud_start_cyc); end
        checks++; if (fd_cyc !== 19) begin failures++; $display("FAIL hud_frame_done_cyc actual=%0d required=19", fd_cyc); end
        checks++; if (map_w !== 1 || spr_w !== 1 || hud_w !== 1) begin failures++; $display("FAIL hud_start_widths actual=%0d,%0d,%0d required=1,1,1", map_w, spr_w, hud_w); end
        checks++; if (grant_log[18] !== 3'b100) begin failures++; $display("FAIL hud_grant_18 actual=%b required=100", grant_log[18]); end
        checks++; if (grant_log[19] !== 3'b000) begin failures++; $display("FAIL hud_grant_19 actual=%b required=000", grant_log[19]); end
        checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL hud_frame_done_count actual=%0d required=1", fd_cnt); end
    endtask

    task automatic test_zero_length();
        init_inputs();
        bus.hud_en = 1;
        apply_reset();
        run_frame(0, 0, 0, 10);
        checks++; if (spr_start_cyc !== 2) begin failures++; $display("FAIL zero_spr_start_cyc actual=%0d required=2", spr_start_cyc); end
        checks++; if (hud_start_cyc !== 3) begin failures++; $display("FAIL zero_hud_start_cyc actual=%0d required=3", hud_start_cyc); end
        checks++; if (fd_cyc !== 4) begin failures++; $display("FAIL zero_frame_done_cyc actual=%0d required=4", fd_cyc); end
    endtask

    task automatic test_plot_isolation();
        init_inputs();
        bus.hud_en = 0;
        bus.map_rom_addr = 16'h1234; bus.spr_rom_addr = 16'h5678; bus.hud_rom_addr = 16'h9ABC;
        bus.map_plot = 0; bus.map_x = 8'd7; bus.map_y = 7'd3; bus.map_colour = 24'h111111;
        bus.spr_plot = 1; bus.spr_x = 8'd40; bus.spr_y = 7'd9; bus.spr_colour = 24'hABCDEF;
        bus.hud_plot = 1; bus.hud_x = 8'd99;
        apply_reset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLOCK_50);
            $display("plot cycle %0d: grant=%b rom=%h vga_plot=%b vga_x=%0d", c, bus.grant, bus.rom_address, bus.vga_plot, bus.vga_x);
            if (c == 1) begin
                checks++; if (bus.grant !== 3'b001) begin failures++; $display("FAIL plot_grant_map actual=%b required=001", bus.grant); end
                checks++; if (bus.rom_address !== 16'h1234) begin failures++; $display("FAIL plot_rom_map actual=%h required=1234", bus.rom_address); end
            end
            if (c == 2) begin
                checks++; if (bus.vga_plot !== 1'b0) begin failures++; $display("FAIL plot_leak_map actual=%b required=0", bus.vga_plot); end
                checks++; if (bus.vga_x !== 8'd7) begin failures++; $display("FAIL plot_vga_x_map actual=%0d required=7", bus.vga_x); end
            end
            if (c == 4) begin
                checks++; if (bus.grant !== 3'b010) begin failures++; $display("FAIL plot_grant_spr actual=%b required=010", bus.grant); end
                checks++; if (bus.rom_address !== 16'h5678) begin failures++; $display("FAIL plot_rom_spr actual=%h required=5678", bus.rom_address); end
                checks++; if (bus.vga_plot !== 1'b0) begin failures++; $display("FAIL plot_leak_latency actual=%b required=0", bus.vga_plot); end
            end
            if (c == 5) begin
                checks++; if (bus.vga_x !== 8'd40 || bus.vga_y !== 7'd9) begin failures++; $display("FAIL plot_vga_xy_spr actual=%0d,%0d required=40,9", bus.vga_x, bus.vga_y); end
                checks++; if (bus.vga_plot !== 1'b1) begin failures++; $display("FAIL plot_vga_plot_spr actual=%b required=1", bus.vga_plot); end
                checks++; if (bus.vga_colour !== 24'hABCDEF) begin failures++; $display("FAIL plot_vga_colour_spr actual=%h required=abcdef", bus.vga_colour); end
            end
            if (c == 7) begin
                checks++; if (bus.grant !== 3'b010) begin failures++; $display("FAIL plot_early_spr_done_ignored actual=%b required=010", bus.grant); end
            end
            bus.spr_done = (c <= 2);
            bus.map_done = (c == 3);
        end
        init_inputs();
    endtask

    task automatic test_watchdog();
        int hud_cnt;
        hud_cnt = 0;
        init_inputs();
        bus_wd.hud_en = 0;
        apply_reset();
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLOCK_50);
            if (bus_wd.hud_start) hud_cnt++;
            if (c == 1) begin
                checks++; if (bus_wd.map_start !== 1'b1) begin failures++; $display("FAIL wd_map_start actual=%b required=1", bus_wd.map_start); end
            end
            if (c == 16) begin
                checks++; if (bus_wd.grant !== 3'b001 || bus_wd.timeout_flags !== 3'b000) begin failures++; $display("FAIL wd_last_map_cycle actual=%b/%b required=001/000", bus_wd.grant, bus_wd.timeout_flags); end
            end
            if (c == 17) begin
                $display("watchdog: map released at cycle 17, flags=%b", bus_wd.timeout_flags);
                checks++; if (bus_wd.spr_start !== 1'b1 || bus_wd.grant !== 3'b010) begin failures++; $display("FAIL wd_spr_follows actual=%b/%b required=1/010", bus_wd.spr_start, bus_wd.grant); end
                checks++; if (bus_wd.timeout_flags !== 3'b001) begin failures++; $display("FAIL wd_map_flag actual=%b required=001", bus_wd.timeout_flags); end
            end
            if (c == 33) begin
                checks++; if (bus_wd.frame_done !== 1'b1 || bus_wd.grant !== 3'b000) begin failures++; $display("FAIL wd_finish actual=%b/%b required=1/000", bus_wd.frame_done, bus_wd.grant); end
                checks++; if (bus_wd.timeout_flags !== 3'b011) begin failures++; $display("FAIL wd_spr_flag actual=%b required=011", bus_wd.timeout_flags); end
            end
        end
        checks++; if (hud_cnt !== 0) begin failures++; $display("FAIL wd_hud_start_count actual=%0d required=0", hud_cnt); end
    endtask

    task automatic test_reset_abort();
        init_inputs();
        bus_wd.hud_en = 0;
        bus_wd.spr_plot = 1; bus_wd.spr_x = 8'd40;
        apply_reset();
        for (int c = 1; c <= 20; c++) @(negedge CLOCK_50);
        checks++; if (bus_wd.vga_plot !== 1'b1 || bus_wd.grant !== 3'b010) begin failures++; $display("FAIL abort_pre_state actual=%b/%b required=1/010", bus_wd.vga_plot, bus_wd.grant); end
        checks++; if (bus_wd.timeout_flags !== 3'b001) begin failures++; $display("FAIL abort_pre_flags actual=%b required=001", bus_wd.timeout_flags); end
        frame_reset = 1;
        #1;
        $display("abort: frame_reset asserted mid SPR_RUN");
        checks++; if (bus_wd.grant !== 3'b000 || bus_wd.vga_plot !== 1'b0) begin failures++; $display("FAIL abort_immediate actual=%b/%b required=000/0", bus_wd.grant, bus_wd.vga_plot); end
        checks++; if (bus_wd.timeout_flags !== 3'b000) begin failures++; $display("FAIL abort_flags_cleared actual=%b required=000", bus_wd.timeout_flags); end
        @(negedge CLOCK_50);
        checks++; if (bus_wd.map_start !== 1'b0 || bus_wd.spr_start !== 1'b0) begin failures++; $display("FAIL abort_no_start_in_reset actual=%b%b required=00", bus_wd.map_start, bus_wd.spr_start); end
        frame_reset = 0;
        @(negedge CLOCK_50);
        checks++; if (bus_wd.map_start !== 1'b1 || bus_wd.grant !== 3'b001) begin failures++; $display("FAIL abort_restart actual=%b/%b required=1/001", bus_wd.map_start, bus_wd.grant); end
        @(negedge CLOCK_50);
        checks++; if (bus_wd.map_start !== 1'b0) begin failures++; $display("FAIL abort_start_width actual=%b required=0", bus_wd.map_start); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        init_inputs();
        frame_reset = 1;
        test_reset();
        test_no_hud();
        test_with_hud();
        test_zero_length();
        test_plot_isolation();
        test_watchdog();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/render_scheduler.md
RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 The block SHALL have parameter WATCHDOG, default 20'd65535, giving the maximum cycles a client may hold the bus before forced release.
REQ-002 The block SHALL have port CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port frame_reset  input  1  reset, asynchronous, active-high; pulsed once per 1/60 s frame.
REQ-004 The block SHALL have port hud_en  input  1  when high, the HUD client is scheduled after the sprite client.
REQ-005 The block SHALL have ports {map,spr,hud}_start  output  1 each  single-cycle start pulse to the map, sprite and HUD drawer.
REQ-006 The block SHALL have ports {map,spr,hud}_done  input  1 each  client-finished indication.
REQ-007 The block SHALL have ports {map,spr,hud}_rom_addr  input  16 each  client ROM address request.
REQ-008 The block SHALL have ports {map,spr,hud}_plot  input  1 each  client VGA write enable.
REQ-009 The block SHALL have ports {map,spr,hud}_x  input  8 each and {map,spr,hud}_y  input  7 each  client pixel coordinates.
REQ-010 The block SHALL have ports {map,spr,hud}_colour  input  24 each  client RGB.
REQ-011 The block SHALL have port rom_address  output  16  shared ROM address.
REQ-012 The block SHALL have ports vga_plot  output  1, vga_x  output  8, vga_y  output  7, vga_colour  output  24  shared VGA adapter bus.
REQ-013 The block SHALL have port grant  output  3  one-hot owner {hud,spr,map}; 3'b000 = no owner.
REQ-014 The block SHALL have port frame_done  output  1  single-cycle pulse when the frame's schedule completes.
REQ-015 The block SHALL have port timeout_flags  output  3  sticky per-client watchdog expiry {hud,spr,map}.

Function
REQ-016 The FSM SHALL have states ARM, MAP_RUN, SPR_RUN, HUD_RUN, FINISH, HOLD.
REQ-017 ARM SHALL advance to MAP_RUN on the next edge, registering map_start=1 and grant=3'b001 and clearing the watchdog.
REQ-018 Each *_start SHALL be high for exactly one cycle: the first cycle of its RUN state.
REQ-019 In a RUN state the watchdog SHALL increment by 1 each cycle, and only the granted client's done SHALL be sampled; done from a non-granted client SHALL be ignored.
REQ-020 A RUN state SHALL end on the edge at which granted done=1 or watchdog==WATCHDOG-1; on watchdog exit without done, the client's timeout_flags bit SHALL set.
REQ-021 On leaving MAP_RUN the FSM SHALL enter SPR_RUN (spr_start=1, grant=3'b010, watchdog=0) on that same edge.
REQ-022 On leaving SPR_RUN the FSM SHALL enter HUD_RUN (hud_start=1, grant=3'b100) if hud_en=1 on that edge, else FINISH.
REQ-023 On leaving HUD_RUN the FSM SHALL enter FINISH.
REQ-024 FINISH SHALL assert frame_done for one cycle with grant=3'b000, then enter HOLD.
REQ-025 HOLD SHALL keep grant=3'b000 and all starts low until frame_reset.
REQ-026 rom_address SHALL be a combinational mux of the granted client's address (client ROM latency unchanged), and 16'h0000 when grant=0.
REQ-027 vga_x/vga_y/vga_colour SHALL be registered copies of the granted client's signals (1-cycle latency).
REQ-028 vga_plot SHALL be registered (granted client's plot AND grant!=0); a non-granted client's plot SHALL never reach vga_plot.
REQ-029 done asserted in the same cycle as a start pulse SHALL be honoured (zero-length draw permitted).

Reset
REQ-030 While frame_reset is high: state=ARM, grant=0, all starts=0, frame_done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, watchdog=0, timeout_flags=0.
REQ-031 frame_reset mid-RUN SHALL abort immediately; the schedule restarts from ARM after deassertion with no extra start pulse in the interim.

Verification
REQ-032 Reset release, hud_en=0, map_done 100 cycles after map_start, spr_done 64 cycles after spr_start -> grant 001 then 010 then 000, frame_done pulse once, hud_start never.
REQ-033 hud_en=1, all clients respond within 10 cycles -> start pulses map, spr, hud in order, each 1 cycle wide, frame_done after hud_done.
REQ-034 WATCHDOG=16, map_done never asserted -> MAP_RUN exits after 16 cycles, timeout_flags=3'b001, spr_start follows on the same edge.
REQ-035 spr_plot=1, spr_x=8'd40 during MAP_RUN, map_plot=0 -> vga_plot=0; on the cycle after grant=010, vga_x=40, vga_plot=1.
REQ-036 frame_reset pulsed during SPR_RUN -> grant=0 and vga_plot=0 immediately, timeout_flags cleared, map_start re-issued one edge after deassertion.
